adc_stream_capture: RTL and testbench

- AXI-Stream slave that terminates the 64-bit ADC sample stream: each word is {timestamp[48:0], sample[14:0]}.
- Stores a run of accepted words in an internal RAM and tracks timestamp gaps and dropped words.
- Ends a capture on a word-count limit or an idle timeout, then reports status to the PS-side register bank.
- Sits between the ADC stream output and the CPU register/readback interface.

---
 rtl/adc_stream_pkg.sv | 25 ++
 rtl/capture_ram.sv | 35 +++
 rtl/adc_stream_capture.sv | 141 ++++++++++++++
 tb/tb_adc_stream_capture.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_stream_pkg.sv
// Shared definitions for the ADC stream capture block: word layout, field bounds
// and capture state encoding.
package adc_stream_pkg;

  localparam int TS_WIDTH     = 49;
  localparam int SAMPLE_WIDTH = 15;
  localparam int TS_MSB       = 63;
  localparam int TS_LSB       = 15;
  localparam int SAMPLE_MSB   = 14;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  typedef struct packed {
    logic        [TS_MSB-TS_LSB:0] ts;
    logic signed [SAMPLE_MSB:0]    sample;
  } adc_word_t;

  // Timestamps are free-running and wrap, so continuity is checked modulo 2^49.
  function automatic logic [TS_WIDTH-1:0] ts_next(input logic [TS_WIDTH-1:0] ts);
    return ts + 49'd1;
  endfunction

endpackage

// File: rtl/capture_ram.sv
// Capture buffer: one write port, one registered read-first read port.
module capture_ram #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [63:0]           i_wr_data,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [63:0]           o_rd_data
);

  logic [63:0] r_mem [0:(1<<ADDR_WIDTH)-1];
  logic [63:0] r_rd_data;

  // Storage array is deliberately left unreset.
  always_ff @(posedge aclk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Non-blocking read of the array gives old data on a same-address collision.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_rd_data <= 64'd0;
    end else begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/adc_stream_capture.sv
// AXI-Stream sink that captures a run of ADC words into RAM and keeps
// per-capture timestamp/sample statistics for the CPU register bank.
module adc_stream_capture
  import adc_stream_pkg::*;
#(
  parameter int ADDR_WIDTH   = 10,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [63:0]           s_axis_tdata,
  input  logic                  arm,
  input  logic                  clear,
  input  logic [ADDR_WIDTH:0]   max_words,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [63:0]           rd_data,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic [TS_WIDTH-1:0]   first_ts,
  output logic [TS_WIDTH-1:0]   last_ts,
  output logic [15:0]           gap_count,
  output logic [SAMPLE_WIDTH-1:0] peak_sample,
  output logic [31:0]           dropped_count
);

  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT);
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [SAMPLE_WIDTH-1:0] PEAK_INIT = 15'h4000;

  logic [1:0]                     r_state;
  logic [ADDR_WIDTH:0]            r_limit;
  logic [ADDR_WIDTH:0]            r_word_count;
  logic [IW-1:0]                  r_idle_cnt;
  logic [TS_WIDTH-1:0]            r_first_ts;
  logic [TS_WIDTH-1:0]            r_last_ts;
  logic [15:0]                    r_gap_count;
  logic signed [SAMPLE_WIDTH-1:0] r_peak;
  logic [31:0]                    r_dropped;

  adc_word_t           w_word;
  logic                w_tready;
  logic                w_xfer;
  logic [ADDR_WIDTH:0] w_limit;
  logic [ADDR_WIDTH:0] w_cnt_next;
  logic [IW-1:0]       w_idle_next;

  assign w_word      = s_axis_tdata;
  assign w_tready    = (r_state == ST_CAPTURE);
  assign w_xfer      = s_axis_tvalid && w_tready;
  assign w_limit     = ((max_words == '0) || (max_words > DEPTH)) ? DEPTH : max_words;
  assign w_cnt_next  = r_word_count + 1'b1;
  assign w_idle_next = r_idle_cnt + IW'(1);

  // Capture FSM and per-capture statistics; reset and clear are equivalent here.
  always_ff @(posedge aclk) begin
    if (!aresetn || clear) begin
      r_state      <= ST_IDLE;
      r_limit      <= '0;
      r_word_count <= '0;
      r_idle_cnt   <= '0;
      r_first_ts   <= '0;
      r_last_ts    <= '0;
      r_gap_count  <= 16'd0;
      r_peak       <= PEAK_INIT;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            r_state      <= ST_CAPTURE;
            r_limit      <= w_limit;
            r_word_count <= '0;
            r_idle_cnt   <= '0;
            r_first_ts   <= '0;
            r_last_ts    <= '0;
            r_gap_count  <= 16'd0;
            r_peak       <= PEAK_INIT;
          end
        end
        ST_CAPTURE: begin
          if (w_xfer) begin
            r_word_count <= w_cnt_next;
            r_last_ts    <= w_word.ts;
            r_idle_cnt   <= '0;
            if (r_word_count == '0) begin
              r_first_ts <= w_word.ts;
            end else if ((w_word.ts != ts_next(r_last_ts)) && (r_gap_count != 16'hFFFF)) begin
              r_gap_count <= r_gap_count + 16'd1;
            end
            if ($signed(w_word.sample) > r_peak) begin
              r_peak <= w_word.sample;
            end
            if (w_cnt_next == r_limit) begin
              r_state <= ST_DONE;
            end
          end else if (r_word_count != '0) begin
            // Idle timer only runs once the capture has started receiving.
            r_idle_cnt <= w_idle_next;
            if (w_idle_next == IDLE_LAST) begin
              r_state <= ST_DONE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Backpressure-ignoring source: count every offered word that is not taken.
  always_ff @(posedge aclk) begin
    if (!aresetn || clear) begin
      r_dropped <= 32'd0;
    end else if (s_axis_tvalid && !w_tready && (r_dropped != 32'hFFFF_FFFF)) begin
      r_dropped <= r_dropped + 32'd1;
    end
  end

  capture_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .i_wr_en   (w_xfer),
    .i_wr_addr (r_word_count[ADDR_WIDTH-1:0]),
    .i_wr_data (s_axis_tdata),
    .i_rd_addr (rd_addr),
    .o_rd_data (rd_data)
  );

  assign s_axis_tready = w_tready;
  assign busy          = (r_state == ST_CAPTURE);
  assign done          = (r_state == ST_DONE);
  assign word_count    = r_word_count;
  assign first_ts      = r_first_ts;
  assign last_ts       = r_last_ts;
  assign gap_count     = r_gap_count;
  assign peak_sample   = r_peak;
  assign dropped_count = r_dropped;

endmodule

// File: tb/tb_adc_stream_capture.sv
// Table-driven and scoreboard-checked bench for adc_stream_capture.
module tb_adc_stream_capture;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [63:0] s_axis_tdata;
  logic        arm;
  logic        clear;
  logic [10:0] max_words;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic        busy;
  logic        done;
  logic [10:0] word_count;
  logic [48:0] first_ts;
  logic [48:0] last_ts;
  logic [15:0] gap_count;
  logic [14:0] peak_sample;
  logic [31:0] dropped_count;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        arm;
    logic        tvalid;
    logic [48:0] ts;
    logic [14:0] smp;
    logic        acc;
    logic        busy;
    logic        done;
    logic [10:0] wc;
    logic [31:0] drop;
  } vec_t;

  typedef struct packed {
    logic [9:0]  addr;
    logic [63:0] data;
  } sb_t;

  vec_t tbl [7];
  sb_t  sb [$];

  always #5 aclk = ~aclk;

  adc_stream_capture #(.ADDR_WIDTH(10), .IDLE_TIMEOUT(64)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .arm           (arm),
    .clear         (clear),
    .max_words     (max_words),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .busy          (busy),
    .done          (done),
    .word_count    (word_count),
    .first_ts      (first_ts),
    .last_ts       (last_ts),
    .gap_count     (gap_count),
    .peak_sample   (peak_sample),
    .dropped_count (dropped_count)
  );

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [48:0] ts, input logic [14:0] smp,
                      input logic push_exp, input logic [9:0] addr);
    sb_t e;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = {ts, smp};
    if (push_exp) begin
      e.addr = addr;
      e.data = {ts, smp};
      sb.push_back(e);
    end
    step();
    s_axis_tvalid = 1'b0;
  endtask

  task automatic readback(input string name);
    sb_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd_addr = e.addr;
      step();
      check($sformatf("%s addr%0d", name, e.addr), rd_data, e.data);
    end
  endtask

  task automatic pulse_arm(input logic [10:0] mw);
    max_words = mw;
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int k;
    // arm, tvalid, ts, smp, acc, busy, done, wc, drop (outputs after the edge)
    tbl[0] = '{1'b1, 1'b0, 49'd0,   15'd0, 1'b0, 1'b1, 1'b0, 11'd0, 32'd0};
    tbl[1] = '{1'b0, 1'b1, 49'd100, 15'd1, 1'b1, 1'b1, 1'b0, 11'd1, 32'd0};
    tbl[2] = '{1'b0, 1'b1, 49'd101, 15'd2, 1'b1, 1'b1, 1'b0, 11'd2, 32'd0};
    tbl[3] = '{1'b0, 1'b1, 49'd102, 15'd3, 1'b1, 1'b1, 1'b0, 11'd3, 32'd0};
    tbl[4] = '{1'b0, 1'b1, 49'd103, 15'd4, 1'b1, 1'b0, 1'b1, 11'd4, 32'd0};
    tbl[5] = '{1'b0, 1'b1, 49'd104, 15'd5, 1'b0, 1'b0, 1'b1, 11'd4, 32'd1};
    tbl[6] = '{1'b0, 1'b1, 49'd105, 15'd6, 1'b0, 1'b0, 1'b1, 11'd4, 32'd2};

    aresetn = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = 64'd0;
    arm = 1'b0; clear = 1'b0; max_words = 11'd0; rd_addr = 10'd0;
    step(); step();
    check("reset ctrl", {busy, done, s_axis_tready}, 64'd0);
    check("reset rd_data", rd_data, 64'd0);
    check("reset word_count", word_count, 64'd0);
    check("reset ts", {first_ts, last_ts}, 64'd0);
    check("reset gap/drop", {gap_count, dropped_count}, 64'd0);
    check("reset peak", peak_sample, 64'h4000);
    aresetn = 1'b1;
    step();

    // Limit of 4 with a continuous source of 6 words
    max_words = 11'd4;
    for (int i = 0; i < 7; i++) begin
      arm = tbl[i].arm;
      s_axis_tvalid = tbl[i].tvalid;
      s_axis_tdata = {tbl[i].ts, tbl[i].smp};
      if (tbl[i].acc) sb.push_back('{tbl[i].wc[9:0] - 10'd1, {tbl[i].ts, tbl[i].smp}});
      step();
      check($sformatf("t1 row%0d", i),
            {busy, done, s_axis_tready, word_count, dropped_count},
            {tbl[i].busy, tbl[i].done, tbl[i].busy, tbl[i].wc, tbl[i].drop});
    end
    arm = 1'b0; s_axis_tvalid = 1'b0;
    check("t1 first_ts", first_ts, 64'd100);
    check("t1 last_ts", last_ts, 64'd103);
    check("t1 gap", gap_count, 64'd0);
    check("t1 peak", peak_sample, 64'd4);
    readback("t1 ram");

    // Idle timeout after gapped timestamps
    pulse_clear();
    pulse_arm(11'd0);
    send(49'd10, 15'd7, 1'b0, 10'd0);
    send(49'd11, 15'd7, 1'b0, 10'd0);
    send(49'd15, 15'd7, 1'b0, 10'd0);
    send(49'd16, 15'd7, 1'b0, 10'd0);
    send(49'd20, 15'd7, 1'b0, 10'd0);
    k = 0;
    while (k < 200) begin
      k++;
      step();
      if (done) break;
    end
    check("t2 idle cycles to done", k, 64'd64);
    check("t2 word_count", word_count, 64'd5);
    check("t2 gap", gap_count, 64'd2);

    // No timeout before the first word; then timestamp wrap
    pulse_clear();
    pulse_arm(11'd0);
    for (int i = 0; i < 80; i++) step();
    check("t3 busy before first word", {busy, done}, 64'd2);
    send(49'h1FFFFFFFFFFFE, 15'd1, 1'b0, 10'd0);
    send(49'h1FFFFFFFFFFFF, 15'd1, 1'b0, 10'd0);
    send(49'h0, 15'd1, 1'b0, 10'd0);
    send(49'h1, 15'd1, 1'b0, 10'd0);
    check("t3 gap", gap_count, 64'd0);
    check("t3 last_ts", last_ts, 64'd1);
    check("t3 first_ts", first_ts, 64'h1FFFFFFFFFFFE);
    pulse_clear();

    // Drops in IDLE, then clear beats arm
    s_axis_tvalid = 1'b1;
    step(); step(); step();
    s_axis_tvalid = 1'b0;
    check("t4 dropped", dropped_count, 64'd3);
    arm = 1'b1; clear = 1'b1;
    step();
    arm = 1'b0; clear = 1'b0;
    check("t4 after clear+arm", {busy, done, s_axis_tready, dropped_count}, 64'd0);

    // Signed peak and readback
    pulse_arm(11'd3);
    send(49'd500, 15'h4001, 1'b1, 10'd0);
    send(49'd501, 15'h3FFF, 1'b1, 10'd1);
    send(49'd502, 15'h0005, 1'b1, 10'd2);
    check("t5 done", {busy, done}, 64'd1);
    check("t5 peak", peak_sample, 64'h3FFF);
    readback("t5 ram");

    // Oversized limit means full depth; re-arm from DONE
    pulse_arm(11'd1500);
    k = 0;
    while (k < 1100) begin
      send(49'd2000 + 49'(k), 15'(k), 1'b0, 10'd0);
      k++;
      if (done) break;
    end
    check("t6 words to done", k, 64'd1024);
    check("t6 word_count", word_count, 64'd1024);
    check("t6 last_ts/gap", {last_ts, gap_count}, {49'd3023, 16'd0});

    // Reset mid-capture, then restart at address 0
    pulse_arm(11'd0);
    send(49'd700, 15'd11, 1'b0, 10'd0);
    send(49'd701, 15'd12, 1'b0, 10'd0);
    send(49'd702, 15'd13, 1'b0, 10'd0);
    aresetn = 1'b0;
    step();
    aresetn = 1'b1;
    check("t7 after reset", {busy, s_axis_tready, word_count}, 64'd0);
    pulse_arm(11'd0);
    send(49'd900, 15'd42, 1'b1, 10'd0);
    check("t7 word_count", word_count, 64'd1);
    readback("t7 ram");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
